// File: rtl/fetch_pkg.sv
// Shared constants for the instruction-fetch stage.
// Covers reset and IM geometry defaults, the NOP word and next-PC select codes.
package fetch_pkg;

    localparam logic [31:0] PC_RESET_DEF = 32'h0000_3000;
    localparam logic [31:0] IM_BASE_DEF  = 32'h0000_3000;
    localparam int          IM_WORDS_DEF = 4096;

    localparam logic [31:0] NOP = 32'h0000_0000;

    typedef enum logic [2:0] {
        NPC_SEQ   = 3'd0,
        NPC_BR    = 3'd1,
        NPC_J     = 3'd2,
        NPC_JR    = 3'd3,
        NPC_FLUSH = 3'd4
    } npc_sel_e;

endpackage

// File: rtl/npc_calc.sv
// Combinational next-PC selection: flush > jr > j > branch > sequential.
// Redirect targets are relative to the D-stage PC (if_id_pc), not the F-stage PC.
module npc_calc
    import fetch_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] if_id_pc,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    input  logic        br_taken,
    input  logic [15:0] br_off,
    input  logic        j_en,
    input  logic [25:0] j_index,
    input  logic        jr_en,
    input  logic [31:0] jr_target,
    output logic [31:0] npc,
    output npc_sel_e    sel
);

    logic        [31:0] pc_d4;
    logic signed [31:0] br_disp;
    logic        [31:0] br_tgt;
    logic        [31:0] j_tgt;

    assign pc_d4   = if_id_pc + 32'd4;
    assign br_disp = signed'({{14{br_off[15]}}, br_off, 2'b00});
    assign br_tgt  = pc_d4 + unsigned'(br_disp);
    assign j_tgt   = {pc_d4[31:28], j_index, 2'b00};

    always_comb begin
        npc = pc + 32'd4;
        sel = NPC_SEQ;
        if (flush) begin
            npc = flush_pc;
            sel = NPC_FLUSH;
        end else if (jr_en) begin
            npc = jr_target;
            sel = NPC_JR;
        end else if (j_en) begin
            npc = j_tgt;
            sel = NPC_J;
        end else if (br_taken) begin
            npc = br_tgt;
            sel = NPC_BR;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, IF/ID pipeline register with stall/flush,
// and fetch address-error detection. Next-PC selection lives in npc_calc.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] PC_RESET = PC_RESET_DEF,
    parameter logic [31:0] IM_BASE  = IM_BASE_DEF,
    parameter int          IM_WORDS = IM_WORDS_DEF
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] pc_out,
    input  logic [31:0] instr_in,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    input  logic        br_taken,
    input  logic [15:0] br_off,
    input  logic        j_en,
    input  logic [25:0] j_index,
    input  logic        jr_en,
    input  logic [31:0] jr_target,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc8,
    output logic        if_id_valid,
    output logic        if_id_exc
);

    // One bit wider so the end-of-IM bound cannot wrap.
    localparam logic [32:0] IM_END = {1'b0, IM_BASE} + 33'(IM_WORDS) * 33'd4;

    logic [31:0] pc_p0;
    logic [31:0] npc;
    npc_sel_e    npc_sel;
    logic        fetch_err;

    logic [31:0] instr_p1;
    logic [31:0] pc_p1;
    logic [31:0] pc8_p1;
    logic        vld_p1;
    logic        exc_p1;

    npc_calc u_npc (
        .pc        (pc_p0),
        .if_id_pc  (pc_p1),
        .flush     (flush),
        .flush_pc  (flush_pc),
        .br_taken  (br_taken),
        .br_off    (br_off),
        .j_en      (j_en),
        .j_index   (j_index),
        .jr_en     (jr_en),
        .jr_target (jr_target),
        .npc       (npc),
        .sel       (npc_sel)
    );

    assign fetch_err = (pc_p0[1:0] != 2'b00) ||
                       (pc_p0 < IM_BASE) ||
                       ({1'b0, pc_p0} >= IM_END);

    // Stage p0: PC register. A flush target overrides a stall.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_p0 <= PC_RESET;
        end else if (npc_sel == NPC_FLUSH || !stall) begin
            pc_p0 <= npc;
        end
    end

    // Stage p1: IF/ID register; the delay slot is latched even on a redirect.
    always_ff @(posedge clk) begin
        if (!reset) begin
            instr_p1 <= NOP;
            pc_p1    <= 32'd0;
            pc8_p1   <= 32'd0;
            vld_p1   <= 1'b0;
            exc_p1   <= 1'b0;
        end else if (flush) begin
            instr_p1 <= NOP;
            vld_p1   <= 1'b0;
            exc_p1   <= 1'b0;
        end else if (!stall) begin
            instr_p1 <= fetch_err ? NOP : instr_in;
            pc_p1    <= pc_p0;
            pc8_p1   <= pc_p0 + 32'd8;
            vld_p1   <= 1'b1;
            exc_p1   <= fetch_err;
        end
    end

    assign pc_out      = pc_p0;
    assign if_id_instr = instr_p1;
    assign if_id_pc    = pc_p1;
    assign if_id_pc8   = pc8_p1;
    assign if_id_valid = vld_p1;
    assign if_id_exc   = exc_p1;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed plus randomized bench for fetch_unit, checked each cycle against a
// behavioural model of the fetch rules.
module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic [31:0] pc_out;
    logic [31:0] instr_in;
    logic        stall;
    logic        flush;
    logic [31:0] flush_pc;
    logic        br_taken;
    logic [15:0] br_off;
    logic        j_en;
    logic [25:0] j_index;
    logic        jr_en;
    logic [31:0] jr_target;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc8;
    logic        if_id_valid;
    logic        if_id_exc;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [31:0] m_pc, m_instr, m_ipc, m_pc8;
    logic        m_valid, m_exc;

    fetch_unit dut (
        .clk         (clk),
        .reset       (reset),
        .pc_out      (pc_out),
        .instr_in    (instr_in),
        .stall       (stall),
        .flush       (flush),
        .flush_pc    (flush_pc),
        .br_taken    (br_taken),
        .br_off      (br_off),
        .j_en        (j_en),
        .j_index     (j_index),
        .jr_en       (jr_en),
        .jr_target   (jr_target),
        .if_id_instr (if_id_instr),
        .if_id_pc    (if_id_pc),
        .if_id_pc8   (if_id_pc8),
        .if_id_valid (if_id_valid),
        .if_id_exc   (if_id_exc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Apply the architectural fetch rules for one clock edge.
    task automatic model_edge();
        logic [31:0] target;
        logic [31:0] disp;
        logic        err;
        if (!reset) begin
            m_pc = 32'h3000; m_instr = 0; m_ipc = 0; m_pc8 = 0; m_valid = 0; m_exc = 0;
        end else if (flush) begin
            m_pc = flush_pc; m_instr = 0; m_valid = 0; m_exc = 0;
        end else if (!stall) begin
            err = (m_pc % 4 != 0) || (m_pc < 32'h3000) || (m_pc >= 32'h3000 + 4 * 4096);
            disp = 32'($signed(br_off)) * 4;
            if (jr_en)         target = jr_target;
            else if (j_en)     target = ((m_ipc + 4) & 32'hF000_0000) | (32'(j_index) * 4);
            else if (br_taken) target = m_ipc + 4 + disp;
            else               target = m_pc + 4;
            m_instr = err ? 32'd0 : instr_in;
            m_ipc   = m_pc;
            m_pc8   = m_pc + 8;
            m_valid = 1'b1;
            m_exc   = err;
            m_pc    = target;
        end
    endtask

    // One clock: update model at the edge, then compare everything at negedge.
    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("pc_out", pc_out, m_pc);
        chk("if_id_instr", if_id_instr, m_instr);
        chk("if_id_pc", if_id_pc, m_ipc);
        chk("if_id_pc8", if_id_pc8, m_pc8);
        chk("if_id_valid", 32'(if_id_valid), 32'(m_valid));
        chk("if_id_exc", 32'(if_id_exc), 32'(m_exc));
        instr_in = $urandom;
    endtask

    task automatic idle_inputs();
        stall = 0; flush = 0; flush_pc = 0; br_taken = 0; br_off = 0;
        j_en = 0; j_index = 0; jr_en = 0; jr_target = 0;
    endtask

    logic [31:0] slot_instr;
    logic [31:0] hold_pc, hold_ipc, hold_instr;

    initial begin
        m_pc = 0; m_instr = 0; m_ipc = 0; m_pc8 = 0; m_valid = 0; m_exc = 0;
        idle_inputs();
        reset = 0;
        instr_in = $urandom;

        // Reset and release
        cycle();
        chk("rst_pc", pc_out, 32'h3000);
        chk("rst_valid", 32'(if_id_valid), 32'd0);
        chk("rst_instr", if_id_instr, 32'd0);
        reset = 1;
        repeat (3) cycle();
        chk("seq_pc", pc_out, 32'h300C);
        chk("seq_ifpc", if_id_pc, 32'h3008);
        chk("seq_pc8", if_id_pc8, 32'h3010);
        chk("seq_valid", 32'(if_id_valid), 32'd1);

        // Branch back with delay slot
        repeat (2) cycle();
        chk("br_setup", if_id_pc, 32'h3010);
        br_taken = 1; br_off = 16'hFFFC; slot_instr = instr_in;
        cycle();
        chk("br_pc", pc_out, 32'h3004);
        chk("br_slot_instr", if_id_instr, slot_instr);
        chk("br_slot_pc", if_id_pc, 32'h3014);
        chk("br_slot_valid", 32'(if_id_valid), 32'd1);
        idle_inputs();

        // Jump, then jr priority over j
        jr_en = 1; jr_target = 32'h3020;
        cycle();
        idle_inputs();
        cycle();
        chk("j_setup", if_id_pc, 32'h3020);
        j_en = 1; j_index = 26'h0000C10;
        cycle();
        chk("j_pc", pc_out, 32'h3040);
        jr_en = 1; jr_target = 32'h3100;
        cycle();
        chk("jr_wins", pc_out, 32'h3100);
        idle_inputs();

        // Stall two cycles with a pending branch
        stall = 1; br_taken = 1; br_off = 16'd2;
        hold_pc = m_pc; hold_ipc = m_ipc; hold_instr = m_instr;
        repeat (2) cycle();
        chk("stall_pc", pc_out, hold_pc);
        chk("stall_ifpc", if_id_pc, hold_ipc);
        chk("stall_instr", if_id_instr, hold_instr);
        stall = 0;
        cycle();
        chk("stall_rel_br", pc_out, 32'h304C);
        idle_inputs();

        // Misaligned and out-of-range fetch
        jr_en = 1; jr_target = 32'h3006;
        cycle();
        idle_inputs();
        cycle();
        chk("mis_instr", if_id_instr, 32'd0);
        chk("mis_exc", 32'(if_id_exc), 32'd1);
        chk("mis_pc", if_id_pc, 32'h3006);
        jr_en = 1; jr_target = 32'h7000;
        cycle();
        idle_inputs();
        cycle();
        chk("oor_exc", 32'(if_id_exc), 32'd1);
        chk("oor_pc", if_id_pc, 32'h7000);

        // Flush over stall, then reset over flush
        flush = 1; stall = 1; flush_pc = 32'h4180;
        cycle();
        chk("flush_pc", pc_out, 32'h4180);
        chk("flush_valid", 32'(if_id_valid), 32'd0);
        reset = 0;
        cycle();
        chk("rst_over_flush", pc_out, 32'h3000);
        reset = 1;
        idle_inputs();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            reset     = ($urandom_range(0, 49) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            stall     = ($urandom_range(0, 4) == 0);
            jr_en     = ($urandom_range(0, 9) == 0);
            j_en      = ($urandom_range(0, 9) == 0);
            br_taken  = ($urandom_range(0, 5) == 0);
            br_off    = 16'($urandom);
            j_index   = 26'(32'h0C00 + $urandom_range(0, 32'h0FFF));
            jr_target = ($urandom_range(0, 7) == 0) ? $urandom
                        : 32'h3000 + 32'($urandom_range(0, 4095)) * 4;
            flush_pc  = 32'h3000 + 32'($urandom_range(0, 4095)) * 4;
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
